clip_sat_pipe: RTL

Multi-channel saturating clipper; next generation of the single-lane clip block. Clamps CHANNELS packed lanes of WIDTH bits to a runtime-programmable [lo, hi] window, signed or unsigned. Uses a 2-stage valid/ready pipeline with backpressure, per-beat saturation flags and a saturation event counter. Sits in the HLS operator library between producer and consumer datapath operators.

---
 rtl/clip_pkg.sv | 51 +++++
 rtl/clip_lane.sv | 34 +++
 rtl/clip_sat_pipe.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/clip_pkg.sv
// Shared constants and helpers for the clip_sat_pipe operator family.
package clip_pkg;

  localparam int DEFAULT_CNT_WIDTH = 16;
  localparam int MAX_W             = 64;

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    return (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
  endfunction

  // Flipping the sign bit of both operands turns a signed compare into an
  // unsigned one, so a single comparator serves both lane modes.
  function automatic logic cmp_lt(input logic [MAX_W-1:0] a,
                                  input logic [MAX_W-1:0] b,
                                  input int               width,
                                  input logic             sgn);
    logic [MAX_W-1:0] flip;
    flip = sgn ? (MAX_W'(1) << (width - 1)) : '0;
    return (a ^ flip) < (b ^ flip);
  endfunction

  function automatic logic [MAX_W-1:0] thr_lo(input int   level,
                                              input logic sgn,
                                              input int   width);
    logic [MAX_W-1:0] mag;
    logic [MAX_W-1:0] half;
    if (!sgn) return '0;
    mag  = MAX_W'(level);
    half = MAX_W'(1) << (width - 1);
    if (mag > half) mag = half;
    return (MAX_W'(0) - mag) & width_mask(width);
  endfunction

  function automatic logic [MAX_W-1:0] thr_hi(input int   level,
                                              input logic sgn,
                                              input int   width);
    logic [MAX_W-1:0] lim;
    logic [MAX_W-1:0] v;
    lim = sgn ? ((MAX_W'(1) << (width - 1)) - MAX_W'(1)) : width_mask(width);
    v   = MAX_W'(level - 1);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int popcount(input logic [MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/clip_lane.sv
// One clipper lane: threshold compares on the incoming value, then the
// clamp select and saturation flag from the registered compare results.
module clip_lane import clip_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic             lt_o,
  output logic             gt_o,
  input  logic [WIDTH-1:0] s1_x_i,
  input  logic [WIDTH-1:0] s1_lo_i,
  input  logic [WIDTH-1:0] s1_hi_i,
  input  logic             s1_lt_i,
  input  logic             s1_gt_i,
  output logic [WIDTH-1:0] z_o,
  output logic             flag_o
);

  localparam logic SGN = (SIGNED != 0);

  assign lt_o = cmp_lt(MAX_W'(x_i), MAX_W'(lo_i), WIDTH, SGN);
  assign gt_o = cmp_lt(MAX_W'(hi_i), MAX_W'(x_i), WIDTH, SGN);

  always_comb begin
    z_o = s1_x_i;
    if (s1_lt_i)      z_o = s1_lo_i;
    else if (s1_gt_i) z_o = s1_hi_i;
  end

  assign flag_o = s1_lt_i | s1_gt_i;

endmodule

// File: rtl/clip_sat_pipe.sv
// Multi-lane saturating clipper with a two-stage valid/ready pipeline.
// Define CLIP_STATS_EN to build the sat_count event counter and clr_count.
module clip_sat_pipe import clip_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int SIGNED    = 1,
  parameter int LEVEL     = 4,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [WIDTH-1:0]          cfg_lo,
  input  logic [WIDTH-1:0]          cfg_hi,
  output logic                      cfg_err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] z,
  output logic [CHANNELS-1:0]       sat_flags,
  input  logic                      clr_count,
  output logic [CNT_WIDTH-1:0]      sat_count
);

  localparam int               XW     = CHANNELS * WIDTH;
  localparam logic             SGN    = (SIGNED != 0);
  localparam logic [WIDTH-1:0] LO_RST = WIDTH'(thr_lo(LEVEL, SGN, WIDTH));
  localparam logic [WIDTH-1:0] HI_RST = WIDTH'(thr_hi(LEVEL, SGN, WIDTH));

  logic [WIDTH-1:0]    lo_q, hi_q, lo_d, hi_d;
  logic                cfg_err_q, cfg_err_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s2_valid_q, s2_valid_d;
  logic [XW-1:0]       s1_x_q;
  logic [WIDTH-1:0]    s1_lo_q, s1_hi_q;
  logic [CHANNELS-1:0] s1_lt_q, s1_gt_q, lt_d, gt_d;
  logic [XW-1:0]       z_q, z_d;
  logic [CHANNELS-1:0] flags_q, flags_d;
  logic                s2_free, s1_adv, accept, xfer;

  assign s2_free    = !s2_valid_q || out_ready;
  assign s1_adv     = s1_valid_q && s2_free;
  assign in_ready   = !s1_valid_q || s2_free;
  assign accept     = in_valid && in_ready;
  assign xfer       = s2_valid_q && out_ready;
  assign s1_valid_d = accept || (s1_valid_q && !s1_adv);
  assign s2_valid_d = s1_adv || (s2_valid_q && !out_ready);

  // An inverted window is rejected whole; the previous thresholds stay live.
  always_comb begin
    lo_d      = lo_q;
    hi_d      = hi_q;
    cfg_err_d = cfg_err_q;
    if (cfg_we) begin
      if (cmp_lt(MAX_W'(cfg_hi), MAX_W'(cfg_lo), WIDTH, SGN)) begin
        cfg_err_d = 1'b1;
      end else begin
        lo_d      = cfg_lo;
        hi_d      = cfg_hi;
        cfg_err_d = 1'b0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    clip_lane #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_lane (
      .x_i     (x[i*WIDTH +: WIDTH]),
      .lo_i    (lo_q),
      .hi_i    (hi_q),
      .lt_o    (lt_d[i]),
      .gt_o    (gt_d[i]),
      .s1_x_i  (s1_x_q[i*WIDTH +: WIDTH]),
      .s1_lo_i (s1_lo_q),
      .s1_hi_i (s1_hi_q),
      .s1_lt_i (s1_lt_q[i]),
      .s1_gt_i (s1_gt_q[i]),
      .z_o     (z_d[i*WIDTH +: WIDTH]),
      .flag_o  (flags_d[i])
    );
  end

  // S1 snapshots the thresholds with the beat so later writes cannot reach it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lo_q       <= LO_RST;
      hi_q       <= HI_RST;
      cfg_err_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      s1_lt_q    <= '0;
      s1_gt_q    <= '0;
      z_q        <= '0;
      flags_q    <= '0;
    end else begin
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      cfg_err_q  <= cfg_err_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_x_q  <= x;
        s1_lo_q <= lo_q;
        s1_hi_q <= hi_q;
        s1_lt_q <= lt_d;
        s1_gt_q <= gt_d;
      end
      if (s1_adv) begin
        z_q     <= z_d;
        flags_q <= flags_d;
      end
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = s2_valid_q;
  assign z         = z_q;
  assign sat_flags = flags_q;

`ifdef CLIP_STATS_EN
  localparam int             SW      = CNT_WIDTH + 8;
  localparam logic [SW-1:0]  CNT_MAX = {8'd0, {CNT_WIDTH{1'b1}}};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SW-1:0]        cnt_sum;

  // Wide sum so a multi-lane increment near the top still saturates cleanly.
  always_comb begin
    cnt_sum = SW'(cnt_q) + SW'(popcount(MAX_W'(flags_q)));
    cnt_d   = cnt_q;
    if (clr_count)  cnt_d = '0;
    else if (xfer)  cnt_d = (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;
`else
  logic unused_stats;
  assign unused_stats = clr_count ^ xfer;
  assign sat_count    = '0;
`endif

endmodule
